systolic_operand_loader: RTL and testbench
==========================================

// Module: systolic_operand_loader
// PURPOSE
//  Upstream feeder for the systolic array's input FIFO (din/wr_fifo/in_fifo_full side).
//  On start, streams M operand words from two operand RAMs and packs each pair into one
//  BUS_WIDTH word per k = 0..M-1:
//   - Matrix A RAM: one A column per word.
//   - Matrix B RAM: one B row per word.
//  Pushes the words in order under FIFO back-pressure. Runs in the sys_clk domain.
// PARAMETERS
//  DIN_WIDTH  8              bits per matrix element
//  N          4              array dimension; elements per A column / B row
//  BUS_WIDTH  2*DIN_WIDTH*N  packed output word width
// PORTS
//  sys_clk       in   1            clock; all logic on rising edge
//  rst_n         in   1            asynchronous active-low reset
//  start         in   1            begin one load of M words; sampled only in IDLE
//  M_minus_one   in   8            M-1 (M = 1..256); captured on accepted start
//  a_rd_en       out  1            A RAM read strobe
//  a_rd_addr     out  8            A RAM word address (= k)
//  a_rd_data     in   N*DIN_WIDTH  A column k; valid 1 cycle after a_rd_en
//  b_rd_en       out  1            B RAM read strobe (always equal to a_rd_en)
//  b_rd_addr     out  8            B RAM word address (always equal to a_rd_addr)
//  b_rd_data     in   N*DIN_WIDTH  B row k; valid 1 cycle after b_rd_en
//  in_fifo_full  in   1            downstream input FIFO full, active high
//  wr_fifo       out  1            FIFO write strobe; every assertion is one accepted word
//  din           out  BUS_WIDTH    packed word {B row k, A column k}
//  busy          out  1            high from accepted start until done
//  done          out  1            one-cycle pulse after the final word is written
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, skid buffer empty, counters 0. Applies mid-operation:
//   the load is discarded, no done pulse, no further RAM reads or FIFO writes.
//  Packing:
//   - din[k_i*DIN_WIDTH +: DIN_WIDTH] = A element i (i = 0..N-1).
//   - din[N*DIN_WIDTH + i*DIN_WIDTH +: DIN_WIDTH] = B element i.
//  FSM:
//   - IDLE -> RUN on start. Captures M_minus_one; rd_cnt = 0, wr_cnt = 0; busy = 1 next cycle.
//   - RUN -> DRAIN when the read of address M-1 is issued.
//   - DRAIN -> DONE when word M-1 is written.
//   - DONE: done = 1 for one cycle, busy = 0 -> IDLE.
//   - start is ignored outside IDLE.
//  Read issue (RUN only): a_rd_en = b_rd_en = 1 and rd_addr = rd_cnt when
//   (skid_occ + inflight - pop) < 2, where:
//   - pop = wr_fifo this cycle;
//   - inflight = 1 if a read was issued last cycle.
//   rd_cnt increments on each issue. rd_addr holds its value when no read is issued.
//  RAM data: captured into a 2-entry skid FIFO in the cycle after issue. It is never
//   dropped: the issue rule guarantees space.
//  Write side:
//   - wr_fifo = skid_nonempty & ~in_fifo_full; combinational on in_fifo_full.
//   - din = skid head when skid is nonempty, otherwise holds its last value.
//   - On wr_fifo the head pops and wr_cnt increments.
//  Throughput: 1 word/cycle with no back-pressure.
//   - First wr_fifo occurs 2 cycles after start (issue, then capture).
//   - done occurs M+2 cycles after the cycle in which start is sampled.
//  Back-pressure: while in_fifo_full = 1 there is no write. Reads stop once 2 words are
//   buffered or in flight. Resuming keeps word order; no loss or duplication.
//  Simultaneous capture and pop in the same cycle are legal: occupancy stays the same.
//  M = 1 (M_minus_one = 0): a single read. The FSM enters DRAIN after 1 cycle in RUN.
//  M = 256 (M_minus_one = 255): rd_cnt wraps to 0 after the last issue. That wrapped value
//   is never issued. wr_cnt is 9 bits.
//  Exactly M wr_fifo pulses occur per start.
// TESTING
//  - Reset, M_minus_one=3, RAM word k = k+1, full=0, start pulse
//    -> wr_fifo high for 4 consecutive cycles from start+2.
//    -> din low half = 1,2,3,4. done at start+6.
//  - M_minus_one=0 -> exactly 1 read at address 0, 1 write, done at start+3, busy cleared.
//  - M_minus_one=7, in_fifo_full=1 during cycles 3..10
//    -> no writes while full. At most 2 reads beyond the last write.
//    -> 8 words in order 0..7 after release.
//  - M_minus_one=255, in_fifo_full toggled pseudo-randomly
//    -> exactly 256 writes, addresses 0..255 each read once, scoreboard match, single done.
//  - start re-pulsed during RUN -> ignored: word count unchanged, one done.
//  - rst_n low mid-load (after 5 writes)
//    -> all outputs 0 immediately, no done.
//    -> a new start after release loads from address 0.

Source files
------------

// File: rtl/systolic_operand_loader.sv
// Streams M operand-word pairs from the A/B RAMs into the systolic array's input FIFO.
// A small 2-entry skid buffer absorbs the RAM read latency so FIFO back-pressure never drops data.
module systolic_operand_loader #(
  parameter int DIN_WIDTH = 8,
  parameter int N         = 4,
  parameter int BUS_WIDTH = 2*DIN_WIDTH*N
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             M_minus_one,
  output logic                   a_rd_en,
  output logic [7:0]             a_rd_addr,
  input  logic [N*DIN_WIDTH-1:0] a_rd_data,
  output logic                   b_rd_en,
  output logic [7:0]             b_rd_addr,
  input  logic [N*DIN_WIDTH-1:0] b_rd_data,
  input  logic                   in_fifo_full,
  output logic                   wr_fifo,
  output logic [BUS_WIDTH-1:0]   din,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [7:0]           m_last;
  logic [7:0]           rd_cnt;
  logic [7:0]           addr_last;
  logic [8:0]           wr_cnt;
  logic                 vld_p1;
  logic [BUS_WIDTH-1:0] skid [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           occ;
  logic [BUS_WIDTH-1:0] din_last;
  logic                 pop;
  logic                 issue;
  logic [2:0]           lvl;

  // Issue only while the words already buffered or in flight leave room in the skid.
  always_comb begin
    pop   = (occ != 2'd0) && !in_fifo_full;
    lvl   = {1'b0, occ} + {2'b0, vld_p1} - {2'b0, pop};
    issue = (state == RUN) && (lvl < 3'd2);
  end

  assign a_rd_en   = issue;
  assign b_rd_en   = issue;
  assign a_rd_addr = issue ? rd_cnt : addr_last;
  assign b_rd_addr = issue ? rd_cnt : addr_last;
  assign wr_fifo   = pop;
  assign din       = (occ != 2'd0) ? skid[rd_ptr] : din_last;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      m_last    <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      addr_last <= '0;
    end else begin
      done <= 1'b0;
      if (issue) begin
        rd_cnt    <= rd_cnt + 8'd1;
        addr_last <= rd_cnt;
      end
      if (pop) wr_cnt <= wr_cnt + 9'd1;
      case (state)
        IDLE: begin
          if (start) begin
            m_last <= M_minus_one;
            rd_cnt <= '0;
            wr_cnt <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (issue && (rd_cnt == m_last)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && (wr_cnt == {1'b0, m_last})) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: RAM data is valid the cycle after issue and lands in the skid buffer.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      skid[0]  <= '0;
      skid[1]  <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= '0;
      din_last <= '0;
    end else begin
      vld_p1 <= issue;
      if (vld_p1) begin
        skid[wr_ptr] <= {b_rd_data, a_rd_data};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, vld_p1} - {1'b0, pop};
      if (occ != 2'd0) din_last <= skid[rd_ptr];
    end
  end

endmodule

// File: tb/tb_systolic_operand_loader.sv
// Directed bench for systolic_operand_loader: RAM model, FIFO-full driver and event logs.
module tb_systolic_operand_loader;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  M_minus_one = 8'd0;
  logic        a_rd_en, b_rd_en;
  logic [7:0]  a_rd_addr, b_rd_addr;
  logic [31:0] a_rd_data = 32'd0;
  logic [31:0] b_rd_data = 32'd0;
  logic        in_fifo_full;
  logic        wr_fifo;
  logic [63:0] din;
  logic        busy, done;

  int total = 0;
  int bad = 0;

  systolic_operand_loader #(.DIN_WIDTH(8), .N(4), .BUS_WIDTH(64)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .M_minus_one(M_minus_one),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .in_fifo_full(in_fifo_full), .wr_fifo(wr_fifo), .din(din),
    .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int full_mode = 0;
  int full_lo = 0;
  int full_hi = 0;
  logic [15:0] lfsr = 16'hACE1;
  always @(posedge sys_clk) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign in_fifo_full = (full_mode == 1) ? (cyc >= full_lo && cyc <= full_hi) :
                        (full_mode == 2) ? lfsr[0] : 1'b0;

  function automatic logic [31:0] a_word(input int k);
    return 32'(k) + 32'd1;
  endfunction

  function automatic logic [31:0] b_word(input int k);
    return 32'hB000_0000 | (32'(k) * 32'd5 + 32'd3);
  endfunction

  always @(posedge sys_clk) begin
    if (a_rd_en) a_rd_data <= a_word(int'(a_rd_addr));
    if (b_rd_en) b_rd_data <= b_word(int'(b_rd_addr));
  end

  logic [63:0] wr_q[$];
  int wr_cyc[$];
  int rd_q[$];
  int done_q[$];
  int max_gap = 0;
  int pair_bad = 0;

  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (wr_fifo) begin
        wr_q.push_back(din);
        wr_cyc.push_back(cyc);
      end
      if (a_rd_en) rd_q.push_back(int'(a_rd_addr));
      if (b_rd_en !== a_rd_en || b_rd_addr !== a_rd_addr) pair_bad++;
      if (done) done_q.push_back(cyc);
      if (rd_q.size() - wr_q.size() > max_gap) max_gap = rd_q.size() - wr_q.size();
    end
  end

  task automatic do_start(input logic [7:0] m, output int s);
    @(negedge sys_clk);
    wr_q.delete(); wr_cyc.delete(); rd_q.delete(); done_q.delete();
    max_gap = 0;
    M_minus_one = m;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_q.size() == 0 && n < limit) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge sys_clk);
    total++;
    if ({wr_fifo, a_rd_en, b_rd_en, busy, done} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {wr_fifo, a_rd_en, b_rd_en, busy, done});
    end
    total++;
    if (din !== 64'h0 || a_rd_addr !== 8'h0 || b_rd_addr !== 8'h0) begin
      bad++; $display("FAIL reset_data: din=%h a=%h b=%h want 0", din, a_rd_addr, b_rd_addr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_basic;
    int s;
    do_start(8'd3, s);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(50);
    total++;
    if (done_q.size() != 1 || done_q[0] != s + 6) begin
      bad++; $display("FAIL basic_done: count=%0d cyc=%0d want 1 at %0d", done_q.size(), done_q[0], s + 6);
    end
    total++;
    if (wr_q.size() != 4) begin bad++; $display("FAIL basic_count: got %0d want 4", wr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wr_cyc[i] != s + 2 + i || wr_q[i] !== {b_word(i), a_word(i)}) begin
        bad++; $display("FAIL basic_word%0d: cyc=%0d din=%h want cyc=%0d din=%h",
                        i, wr_cyc[i], wr_q[i], s + 2 + i, {b_word(i), a_word(i)});
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_single;
    int s;
    do_start(8'd0, s);
    wait_done(50);
    total++;
    if (rd_q.size() != 1 || rd_q[0] != 0) begin
      bad++; $display("FAIL single_reads: count=%0d addr=%0d want 1 at 0", rd_q.size(), rd_q[0]);
    end
    total++;
    if (wr_q.size() != 1 || wr_q[0] !== {b_word(0), a_word(0)}) begin
      bad++; $display("FAIL single_write: count=%0d din=%h want 1 of %h", wr_q.size(), wr_q[0], {b_word(0), a_word(0)});
    end
    total++;
    if (done_q.size() != 1 || done_q[0] != s + 3 || busy !== 1'b0) begin
      bad++; $display("FAIL single_done: count=%0d cyc=%0d busy=%b want 1 at %0d busy 0",
                      done_q.size(), done_q[0], busy, s + 3);
    end
  endtask

  task automatic test_backpressure;
    int s;
    int during;
    do_start(8'd7, s);
    full_lo = s + 3;
    full_hi = s + 10;
    full_mode = 1;
    wait_done(100);
    full_mode = 0;
    during = 0;
    foreach (wr_cyc[i]) if (wr_cyc[i] >= s + 3 && wr_cyc[i] <= s + 10) during++;
    total++;
    if (during != 0) begin bad++; $display("FAIL bp_write_while_full: got %0d want 0", during); end
    total++;
    if (max_gap > 2) begin bad++; $display("FAIL bp_read_ahead: got %0d want <=2", max_gap); end
    total++;
    if (wr_q.size() != 8) begin bad++; $display("FAIL bp_count: got %0d want 8", wr_q.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (wr_q[i] !== {b_word(i), a_word(i)}) begin
        bad++; $display("FAIL bp_word%0d: got %h want %h", i, wr_q[i], {b_word(i), a_word(i)});
      end
    end
    total++;
    if (wr_cyc[1] != s + 11 || done_q.size() != 1 || done_q[0] != s + 18) begin
      bad++; $display("FAIL bp_timing: resume=%0d done=%0d x%0d want %0d, %0d x1",
                      wr_cyc[1], done_q[0], done_q.size(), s + 11, s + 18);
    end
  endtask

  task automatic test_long;
    int s;
    do_start(8'd255, s);
    full_mode = 2;
    wait_done(3000);
    full_mode = 0;
    total++;
    if (wr_q.size() != 256 || rd_q.size() != 256) begin
      bad++; $display("FAIL long_count: writes=%0d reads=%0d want 256/256", wr_q.size(), rd_q.size());
    end
    for (int i = 0; i < 256; i++) begin
      total++;
      if (rd_q[i] != i || wr_q[i] !== {b_word(i), a_word(i)}) begin
        bad++; $display("FAIL long_item%0d: addr=%0d din=%h want %0d %h", i, rd_q[i], wr_q[i], i, {b_word(i), a_word(i)});
      end
    end
    total++;
    if (done_q.size() != 1 || max_gap > 2) begin
      bad++; $display("FAIL long_done: dones=%0d gap=%0d want 1 and <=2", done_q.size(), max_gap);
    end
    total++;
    if (pair_bad != 0) begin bad++; $display("FAIL ab_port_match: got %0d want 0", pair_bad); end
  endtask

  task automatic test_restart_ignored;
    int s;
    do_start(8'd5, s);
    @(negedge sys_clk);
    M_minus_one = 8'd1;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_done(50);
    repeat (6) @(negedge sys_clk);
    total++;
    if (wr_q.size() != 6 || done_q.size() != 1 || done_q[0] != s + 8) begin
      bad++; $display("FAIL restart: writes=%0d dones=%0d cyc=%0d want 6, 1 at %0d",
                      wr_q.size(), done_q.size(), done_q[0], s + 8);
    end
  endtask

  task automatic test_reset_mid;
    int s;
    int n = 0;
    int nwr;
    do_start(8'd19, s);
    while (wr_q.size() < 5 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    nwr = wr_q.size();
    total++;
    if ({wr_fifo, a_rd_en, b_rd_en, busy, done} !== 5'b0 || din !== 64'h0 ||
        a_rd_addr !== 8'h0 || b_rd_addr !== 8'h0) begin
      bad++; $display("FAIL midreset_outputs: ctrl=%b din=%h addr=%h want all 0",
                      {wr_fifo, a_rd_en, b_rd_en, busy, done}, din, a_rd_addr);
    end
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    total++;
    if (done_q.size() != 0 || wr_q.size() != nwr || nwr < 5) begin
      bad++; $display("FAIL midreset_quiet: dones=%0d writes=%0d want 0 and %0d (>=5)", done_q.size(), wr_q.size(), nwr);
    end
    do_start(8'd1, s);
    wait_done(50);
    total++;
    if (rd_q.size() != 2 || rd_q[0] != 0 || wr_q.size() != 2 || wr_q[0] !== {b_word(0), a_word(0)} ||
        wr_q[1] !== {b_word(1), a_word(1)}) begin
      bad++; $display("FAIL midreset_reload: reads=%0d first=%0d writes=%0d din0=%h want 2 from 0",
                      rd_q.size(), rd_q[0], wr_q.size(), wr_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_long();
    test_restart_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
